johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder.sv | 156 +++++++++++++++
 tb/tb_johnson_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// ============================================================================
// Module   : johnson_decoder
// Brief    : Decodes an N-bit Johnson code to its index and tracks sequence
//            lock; optional error counter enabled by JOHNSON_DECODER_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_LEN = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [N-1:0]             code,
    output logic [$clog2(2*N)-1:0]   index,
    output logic                     idx_valid,
    output logic                     illegal,
    output logic                     seq_err,
    output logic                     locked,
    output logic [7:0]               err_count
);

    localparam int         W      = $clog2(2*N);
    localparam logic [W-1:0] c_LAST = W'(2*N - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t         r_state_q;
    logic [3:0]     r_run_q;
    logic [W-1:0]   r_index_q;
    logic           r_idx_valid_q;
    logic           r_illegal_q;
    logic           r_seq_err_q;
    logic           r_locked_q;

    logic           w_legal;
    logic [W-1:0]   w_dec_idx;
    logic [W-1:0]   w_exp_idx;
    logic           w_is_succ;
    logic [3:0]     w_run_inc;
    logic [N-1:0]   w_code_inv;

    // A run of ones anchored at bit 0 satisfies x & (x+1) == 0; the MSB=1
    // half of the cycle is the same pattern after inversion.
    always_comb begin
        int ones;
        ones       = 0;
        w_code_inv = ~code;
        for (int i = 0; i < N; i++) begin
            ones = ones + int'(code[i]);
        end
        if (!code[N-1]) begin
            w_legal   = ((code & (code + N'(1))) == '0);
            w_dec_idx = W'(ones);
        end else begin
            w_legal   = ((w_code_inv & (w_code_inv + N'(1))) == '0);
            w_dec_idx = W'(2*N - ones);
        end
    end

    assign w_exp_idx = (r_index_q == c_LAST) ? '0 : r_index_q + W'(1);
    assign w_is_succ = (w_dec_idx == w_exp_idx);
    assign w_run_inc = r_run_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q     <= SEARCH;
            r_run_q       <= 4'd0;
            r_index_q     <= '0;
            r_idx_valid_q <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_seq_err_q   <= 1'b0;
            r_locked_q    <= 1'b0;
        end else begin
            r_idx_valid_q <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_seq_err_q   <= 1'b0;
            if (valid) begin
                if (!w_legal) begin
                    r_illegal_q <= 1'b1;
                    r_state_q   <= SEARCH;
                    r_run_q     <= 4'd0;
                    r_locked_q  <= 1'b0;
                end else begin
                    r_idx_valid_q <= 1'b1;
                    r_index_q     <= w_dec_idx;
                    case (r_state_q)
                        SEARCH: begin
                            r_state_q <= TRACK;
                            r_run_q   <= 4'd0;
                        end
                        TRACK: begin
                            if (w_is_succ) begin
                                r_run_q <= w_run_inc;
                                if (int'(w_run_inc) >= LOCK_LEN) begin
                                    r_state_q  <= LOCK;
                                    r_locked_q <= 1'b1;
                                end
                            end else begin
                                r_run_q <= 4'd0;
                            end
                        end
                        LOCK: begin
                            if (!w_is_succ) begin
                                r_seq_err_q <= 1'b1;
                                r_state_q   <= TRACK;
                                r_run_q     <= 4'd0;
                                r_locked_q  <= 1'b0;
                            end
                        end
                        default: begin
                            r_state_q  <= SEARCH;
                            r_run_q    <= 4'd0;
                            r_locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef JOHNSON_DECODER_ERRCNT_EN
    logic [7:0] r_err_cnt_q;
    logic       w_err_evt;

    // Only losses of an established lock count: skips and illegal codes in LOCK.
    assign w_err_evt = valid && (r_state_q == LOCK) && (!w_legal || !w_is_succ);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_cnt_q <= 8'd0;
        end else if (w_err_evt && (r_err_cnt_q != 8'hFF)) begin
            r_err_cnt_q <= r_err_cnt_q + 8'd1;
        end
    end

    assign err_count = r_err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

    assign index     = r_index_q;
    assign idx_valid = r_idx_valid_q;
    assign illegal   = r_illegal_q;
    assign seq_err   = r_seq_err_q;
    assign locked    = r_locked_q;

endmodule

`default_nettype wire

// File: tb/tb_johnson_decoder.sv
// ============================================================================
// Module   : tb_johnson_decoder
// Brief    : Scoreboard bench for johnson_decoder (N=4, LOCK_LEN=3) against a
//            table-driven reference model; follows JOHNSON_DECODER_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int LOCK_LEN = 3;
    localparam int P        = 2 * N;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [3:0] code;
    logic [2:0] index;
    logic       idx_valid;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    johnson_decoder #(.N(N), .LOCK_LEN(LOCK_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .code      (code),
        .index     (index),
        .idx_valid (idx_valid),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit iv;
        bit ill;
        bit se;
        bit lk;
        int ec;
    } exp_t;

    exp_t       sb[$];
    exp_t       pend;
    int         total = 0;
    int         bad   = 0;

    logic [3:0] seq_tab[P];
    int         m_mode;   // 0 search, 1 track, 2 lock
    int         m_idx;
    int         m_run;
    int         m_err;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < P; i++) begin
            if (seq_tab[i] == c) return i;
        end
        return -1;
    endfunction

    function automatic void model(input bit r, input bit v, input logic [3:0] c);
        int  k;
        bit  err_evt;
        err_evt  = 1'b0;
        pend.iv  = 1'b0;
        pend.ill = 1'b0;
        pend.se  = 1'b0;
        if (!r) begin
            m_mode = 0; m_idx = 0; m_run = 0; m_err = 0;
        end else if (v) begin
            k = lookup(c);
            if (k < 0) begin
                pend.ill = 1'b1;
                if (m_mode == 2) err_evt = 1'b1;
                m_mode = 0;
                m_run  = 0;
            end else begin
                pend.iv = 1'b1;
                if (m_mode == 0) begin
                    m_mode = 1;
                    m_run  = 0;
                end else if (k == (m_idx + 1) % P) begin
                    if (m_mode == 1) begin
                        m_run++;
                        if (m_run >= LOCK_LEN) m_mode = 2;
                    end
                end else begin
                    if (m_mode == 2) begin
                        pend.se = 1'b1;
                        err_evt = 1'b1;
                    end
                    m_mode = 1;
                    m_run  = 0;
                end
                m_idx = k;
            end
        end
`ifdef JOHNSON_DECODER_ERRCNT_EN
        if (err_evt && m_err < 255) m_err++;
`endif
        pend.idx = m_idx;
        pend.lk  = (m_mode == 2);
        pend.ec  = m_err;
    endfunction

    task automatic step(input bit r, input bit v, input logic [3:0] c);
        reset = r;
        valid = v;
        code  = c;
        model(r, v, c);
        @(posedge clk);
        sb.push_back(pend);
        #1;
    endtask

    task automatic feed_pos(input int p);
        step(1'b1, 1'b1, seq_tab[p % P]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("index",     int'(index),     e.idx);
            chk("idx_valid", int'(idx_valid), int'(e.iv));
            chk("illegal",   int'(illegal),   int'(e.ill));
            chk("seq_err",   int'(seq_err),   int'(e.se));
            chk("locked",    int'(locked),    int'(e.lk));
            chk("err_count", int'(err_count), e.ec);
        end
    end

    initial begin
        int pos;
        int sel;
        seq_tab[0] = 4'b0000;
        for (int i = 1; i < P; i++) begin
            seq_tab[i] = {seq_tab[i-1][2:0], ~seq_tab[i-1][3]};
        end
        m_mode = 0; m_idx = 0; m_run = 0; m_err = 0;
        reset = 1'b0; valid = 1'b0; code = 4'b0000;

        // Reset held with a live sample on the bus
        step(1'b0, 1'b1, 4'b0111);
        step(1'b0, 1'b1, 4'b0111);

        // Lock, wrap, skip, relock, illegal
        for (int p = 0; p <= 3; p++) feed_pos(p);
        for (int p = 4; p <= 8; p++) feed_pos(p);
        feed_pos(1);
        feed_pos(2);
        feed_pos(4);
        feed_pos(5);
        step(1'b1, 1'b0, 4'b0101);
        feed_pos(6);
        feed_pos(7);
        step(1'b1, 1'b1, 4'b0101);
        step(1'b1, 1'b0, 4'b0000);

        // Mid-stream reset must force a full relock
        for (int p = 0; p <= 5; p++) feed_pos(p);
        step(1'b0, 1'b1, seq_tab[6]);
        for (int p = 7; p <= 12; p++) feed_pos(p);

        // Randomized walk with skips, illegal codes, repeats and idle cycles
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                step(1'b1, 1'b0, 4'($urandom));
            end else if (sel == 1) begin
                step(1'b0, 1'($urandom), 4'($urandom));
            end else if (sel <= 14) begin
                pos = (pos + 1) % P;
                feed_pos(pos);
            end else if (sel <= 16) begin
                pos = int'($urandom_range(0, P - 1));
                feed_pos(pos);
            end else if (sel == 17) begin
                step(1'b1, 1'b1, 4'($urandom));
            end else begin
                feed_pos(pos);
            end
        end

        // Saturation: repeated lock-then-skip events
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p <= 3; p++) feed_pos(p);
            feed_pos(5);
        end
        step(1'b1, 1'b0, 4'b0000);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
